// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the register file: WB has priority, AUX returns
// are queued in a small FIFO, and a starvation counter eventually forces the
// AUX head through. A scoreboard tracks registers awaiting an AUX write.
module regfile_write_sched #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  localparam int unsigned AW          = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_dest,
  input  logic [WIDTH-1:0]    wb_data,
  output logic                wb_stall,
  input  logic                aux_valid,
  output logic                aux_ready,
  input  logic [AW-1:0]       aux_dest,
  input  logic [WIDTH-1:0]    aux_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_dest,
  output logic [NUM_REGS-1:0] load,
  output logic [WIDTH-1:0]    wdata,
  output logic [NUM_REGS-1:0] pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0]    dest;
    logic [WIDTH-1:0] data;
  } aux_entry_t;

  aux_entry_t          fifo_q [DEPTH];
  logic [PW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]       count_q, count_nxt;
  logic [SW-1:0]       wait_cnt_q, wait_cnt_nxt;
  logic [NUM_REGS-1:0] pending_q, pending_nxt;

  aux_entry_t          head;
  logic                has_head;
  logic                force_aux;
  logic                grant_aux;
  logic                grant_wb;
  logic                push;

  assign head      = fifo_q[rd_ptr_q];
  assign has_head  = (count_q != '0);
  assign force_aux = has_head && (wait_cnt_q == SW'(STARVE_LIMIT));
  assign aux_ready = ~reset & (count_q != CW'(DEPTH));
  assign push      = aux_valid & aux_ready;
  assign pending   = reset ? '0 : pending_q;

  // Write-port arbitration: forced AUX, then WB, then AUX when WB is idle.
  always_comb begin
    grant_aux = 1'b0;
    grant_wb  = 1'b0;
    wb_stall  = 1'b0;
    load      = '0;
    wdata     = '0;
    if (!reset) begin
      if (force_aux) begin
        grant_aux = 1'b1;
        wb_stall  = wb_valid;
      end else if (wb_valid) begin
        grant_wb = 1'b1;
      end else if (has_head) begin
        grant_aux = 1'b1;
      end
      if (grant_aux) begin
        load  = NUM_REGS'(1) << head.dest;
        wdata = head.data;
      end else if (grant_wb) begin
        load  = NUM_REGS'(1) << wb_dest;
        wdata = wb_data;
      end
    end
  end

  // Next-state for occupancy, starvation counter and scoreboard.
  always_comb begin
    count_nxt    = count_q;
    wait_cnt_nxt = wait_cnt_q;
    pending_nxt  = pending_q;
    case ({push, grant_aux})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
    if (grant_aux || !has_head) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt_q != SW'(STARVE_LIMIT)) begin
      wait_cnt_nxt = wait_cnt_q + SW'(1);
    end
    // Clear before set so a same-cycle issue to the granted register wins.
    if (grant_aux) begin
      pending_nxt[head.dest] = 1'b0;
    end
    if (issue_valid) begin
      pending_nxt[issue_dest] = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      pending_q  <= '0;
    end else begin
      count_q    <= count_nxt;
      wait_cnt_q <= wait_cnt_nxt;
      pending_q  <= pending_nxt;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (grant_aux) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{dest: aux_dest, data: aux_data};
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Self-checking bench for regfile_write_sched: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_write_sched;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        wb_stall;
  logic        aux_valid;
  logic        aux_ready;
  logic [2:0]  aux_dest;
  logic [15:0] aux_data;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic [7:0]  load;
  logic [15:0] wdata;
  logic [7:0]  pending;

  int tests = 0;
  int fails = 0;

  regfile_write_sched #(.WIDTH(16), .NUM_REGS(8), .DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_stall(wb_stall),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_dest(aux_dest), .aux_data(aux_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .load(load), .wdata(wdata), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wb_valid = 0; wb_dest = 0; wb_data = 0;
    aux_valid = 0; aux_dest = 0; aux_data = 0;
    issue_valid = 0; issue_dest = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_wb();
    wb_dest = 3'($urandom);
    wb_data = 16'($urandom);
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    wb_valid = 1; wb_dest = 3; wb_data = 16'h1234;
    aux_valid = 1; aux_dest = 1; issue_valid = 1; issue_dest = 1;
    tick();
    #2;
    tests++; if (load !== 8'h00) begin fails++; $display("FAIL reset_load: got %h exp 00", load); end
    tests++; if (wb_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b exp 0", wb_stall); end
    tests++; if (aux_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b exp 0", aux_ready); end
    tests++; if (pending !== 8'h00) begin fails++; $display("FAIL reset_pending: got %h exp 00", pending); end
    tick();
    reset = 0; aux_valid = 0; issue_valid = 0;
    #2;
    tests++; if (load !== 8'b0000_1000) begin fails++; $display("FAIL wb_only_load: got %h exp 08", load); end
    tests++; if (wdata !== 16'h1234) begin fails++; $display("FAIL wb_only_wdata: got %h exp 1234", wdata); end
    tests++; if (wb_stall !== 1'b0) begin fails++; $display("FAIL wb_only_stall: got %b exp 0", wb_stall); end
    tests++; if (aux_ready !== 1'b1) begin fails++; $display("FAIL wb_only_ready: got %b exp 1", aux_ready); end
    tick();
    idle();
  endtask

  task automatic test_single_aux();
    idle(); issue_valid = 1; issue_dest = 5;
    #2;
    tests++; if (pending !== 8'h00) begin fails++; $display("FAIL single_pend0: got %h exp 00", pending); end
    tick();
    issue_valid = 0; aux_valid = 1; aux_dest = 5; aux_data = 16'hBEEF;
    #2;
    tests++; if (pending !== 8'h20) begin fails++; $display("FAIL single_pend1: got %h exp 20", pending); end
    tests++; if (load !== 8'h00) begin fails++; $display("FAIL single_nobypass: got %h exp 00", load); end
    tick();
    aux_valid = 0;
    #2;
    tests++; if (load !== 8'h20) begin fails++; $display("FAIL single_load: got %h exp 20", load); end
    tests++; if (wdata !== 16'hBEEF) begin fails++; $display("FAIL single_wdata: got %h exp beef", wdata); end
    tick();
    #2;
    tests++; if (pending !== 8'h00) begin fails++; $display("FAIL single_pend_clr: got %h exp 00", pending); end
    tests++; if (load !== 8'h00) begin fails++; $display("FAIL single_empty: got %h exp 00", load); end
    tick();
  endtask

  task automatic test_full();
    logic [7:0]  exp_load;
    logic [15:0] exp_data;
    idle(); wb_valid = 1;
    for (int i = 0; i < 4; i++) begin
      rand_wb(); aux_valid = 1; aux_dest = 3'(i); aux_data = 16'hA000 + 16'(i);
      exp_load = 8'd1 << wb_dest;
      #2;
      tests++; if (aux_ready !== 1'b1) begin fails++; $display("FAIL full_ready_%0d: got %b exp 1", i, aux_ready); end
      tests++; if (load !== exp_load) begin fails++; $display("FAIL full_wb_load_%0d: got %h exp %h", i, load, exp_load); end
      tick();
    end
    rand_wb(); aux_valid = 1; aux_dest = 7; aux_data = 16'hDEAD;
    #2;
    tests++; if (aux_ready !== 1'b0) begin fails++; $display("FAIL full_ready_full: got %b exp 0", aux_ready); end
    tests++; if (load !== 8'h01) begin fails++; $display("FAIL full_force_load: got %h exp 01", load); end
    tests++; if (wdata !== 16'hA000) begin fails++; $display("FAIL full_force_wdata: got %h exp a000", wdata); end
    tests++; if (wb_stall !== 1'b1) begin fails++; $display("FAIL full_force_stall: got %b exp 1", wb_stall); end
    tick();
    aux_valid = 0; rand_wb(); exp_load = 8'd1 << wb_dest;
    #2;
    tests++; if (load !== exp_load || wb_stall !== 1'b0) begin fails++; $display("FAIL full_wb_after: load %h stall %b exp %h 0", load, wb_stall, exp_load); end
    tick();
    wb_valid = 0;
    for (int k = 1; k < 4; k++) begin
      exp_load = 8'd1 << k; exp_data = 16'hA000 + 16'(k);
      #2;
      tests++; if (load !== exp_load || wdata !== exp_data) begin fails++; $display("FAIL full_drain_%0d: got %h/%h exp %h/%h", k, load, wdata, exp_load, exp_data); end
      tick();
    end
    #2;
    tests++; if (load !== 8'h00) begin fails++; $display("FAIL full_no_extra: got %h/%h exp 00", load, wdata); end
    tick();
  endtask

  task automatic test_starve();
    logic [7:0] exp_load;
    idle(); wb_valid = 1; aux_valid = 1; aux_dest = 6; aux_data = 16'h5A5A;
    for (int c = 0; c < 4; c++) begin
      rand_wb(); exp_load = 8'd1 << wb_dest;
      #2;
      tests++; if (load !== exp_load || wb_stall !== 1'b0) begin fails++; $display("FAIL starve_wb_%0d: load %h stall %b exp %h 0", c, load, wb_stall, exp_load); end
      tick();
      aux_valid = 0;
    end
    rand_wb();
    #2;
    tests++; if (load !== 8'h40 || wdata !== 16'h5A5A) begin fails++; $display("FAIL starve_force: got %h/%h exp 40/5a5a", load, wdata); end
    tests++; if (wb_stall !== 1'b1) begin fails++; $display("FAIL starve_stall: got %b exp 1", wb_stall); end
    tick();
    exp_load = 8'd1 << wb_dest;
    #2;
    tests++; if (load !== exp_load || wb_stall !== 1'b0) begin fails++; $display("FAIL starve_resume: load %h stall %b exp %h 0", load, wb_stall, exp_load); end
    tick();
    idle();
    #2;
    tests++; if (load !== 8'h00) begin fails++; $display("FAIL starve_empty: got %h exp 00", load); end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_load;
    logic [15:0] exp_data;
    idle(); aux_valid = 1; aux_dest = 0; aux_data = 16'hC000;
    tick();
    for (int k = 1; k <= 10; k++) begin
      aux_dest = 3'(k % 8); aux_data = 16'hC000 + 16'(k);
      exp_load = 8'd1 << ((k - 1) % 8); exp_data = 16'hC000 + 16'(k - 1);
      #2;
      tests++; if (load !== exp_load || wdata !== exp_data || aux_ready !== 1'b1) begin fails++; $display("FAIL wrap_%0d: got %h/%h rdy %b exp %h/%h", k, load, wdata, aux_ready, exp_load, exp_data); end
      tick();
    end
    aux_valid = 0;
    #2;
    tests++; if (load !== 8'h04 || wdata !== 16'hC00A) begin fails++; $display("FAIL wrap_last: got %h/%h exp 04/c00a", load, wdata); end
    tick();
    #2;
    tests++; if (load !== 8'h00) begin fails++; $display("FAIL wrap_empty: got %h exp 00", load); end
    tick();
  endtask

  task automatic test_collision();
    idle(); issue_valid = 1; issue_dest = 2; aux_valid = 1; aux_dest = 2; aux_data = 16'h2222;
    tick();
    aux_valid = 0;
    #2;
    tests++; if (load !== 8'h04 || wdata !== 16'h2222) begin fails++; $display("FAIL coll_grant: got %h/%h exp 04/2222", load, wdata); end
    tick();
    issue_valid = 0;
    #2;
    tests++; if (pending !== 8'h04) begin fails++; $display("FAIL coll_set_wins: got %h exp 04", pending); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); wb_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rand_wb(); aux_valid = 1; aux_dest = 3'(i + 4); aux_data = 16'(i);
      issue_valid = 1; issue_dest = 3'(i);
      tick();
    end
    reset = 1; issue_valid = 0;
    #2;
    tests++; if (load !== 8'h00 || wb_stall !== 1'b0 || aux_ready !== 1'b0 || pending !== 8'h00) begin fails++; $display("FAIL rmid_during: load %h stall %b rdy %b pend %h", load, wb_stall, aux_ready, pending); end
    tick();
    reset = 0; idle();
    #2;
    tests++; if (load !== 8'h00 || pending !== 8'h00 || aux_ready !== 1'b1) begin fails++; $display("FAIL rmid_after: load %h pend %h rdy %b exp 00 00 1", load, pending, aux_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [2:0]  mq_dest[$];
    logic [15:0] mq_data[$];
    int          starve;
    logic [7:0]  mpend;
    int          sz;
    logic        rst, frc, gaux, gwb;
    logic [7:0]  e_load;
    logic [15:0] e_data;
    logic        e_stall, e_ready;
    logic [7:0]  e_pend;
    idle(); reset = 1; tick(); reset = 0;
    starve = 0; mpend = 0;
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      reset       = rst;
      wb_valid    = ($urandom_range(0, 9) < 6);
      rand_wb();
      aux_valid   = $urandom_range(0, 1) == 1;
      aux_dest    = 3'($urandom);
      aux_data    = 16'($urandom);
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_dest  = 3'($urandom);
      sz = mq_dest.size();
      frc = (sz != 0) && (starve >= 3);
      gaux = !rst && (frc || (!wb_valid && sz != 0));
      gwb  = !rst && wb_valid && !frc;
      e_load = 0; e_data = 0;
      if (gaux) begin e_load = 8'd1 << mq_dest[0]; e_data = mq_data[0]; end
      else if (gwb) begin e_load = 8'd1 << wb_dest; e_data = wb_data; end
      e_stall = !rst && frc && wb_valid;
      e_ready = !rst && (sz < 4);
      e_pend  = rst ? 8'h00 : mpend;
      #2;
      tests++; if (load !== e_load) begin fails++; $display("FAIL rand_load c%0d: got %h exp %h", n, load, e_load); end
      tests++; if (e_load != 0 && wdata !== e_data) begin fails++; $display("FAIL rand_wdata c%0d: got %h exp %h", n, wdata, e_data); end
      tests++; if (wb_stall !== e_stall) begin fails++; $display("FAIL rand_stall c%0d: got %b exp %b", n, wb_stall, e_stall); end
      tests++; if (aux_ready !== e_ready) begin fails++; $display("FAIL rand_ready c%0d: got %b exp %b", n, aux_ready, e_ready); end
      tests++; if (pending !== e_pend) begin fails++; $display("FAIL rand_pending c%0d: got %h exp %h", n, pending, e_pend); end
      if (rst) begin
        mq_dest.delete(); mq_data.delete(); starve = 0; mpend = 0;
      end else begin
        if (gaux) begin
          mpend[mq_dest[0]] = 1'b0;
          void'(mq_dest.pop_front()); void'(mq_data.pop_front());
        end
        if (aux_valid && sz < 4) begin
          mq_dest.push_back(aux_dest); mq_data.push_back(aux_data);
        end
        starve = (gaux || sz == 0) ? 0 : ((starve < 3) ? starve + 1 : 3);
        if (issue_valid) mpend[issue_dest] = 1'b1;
      end
      tick();
    end
    reset = 0; idle();
  endtask

  initial begin
    idle(); reset = 1;
    test_reset();
    test_single_aux();
    test_full();
    test_starve();
    test_wrap();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Single-write-port scheduler for the CPU register file, which is built from NUM_REGS negedge-captured registers (load enable plus shared data in).
- Shares the write port between two requesters:
  - the pipeline writeback (WB), which has priority and no backpressure;
  - an auxiliary return path (AUX: memory loads, multicycle units), which uses valid/ready and is buffered in a small FIFO.
- Also keeps a pending scoreboard so decode can stall on registers with outstanding AUX writes.
- Prevents AUX starvation by forcing a WB stall after a bounded wait.

Parameters:
- WIDTH, 16, register data width
- NUM_REGS, 8, number of architectural registers; AW = $clog2(NUM_REGS) is derived, not a parameter
- DEPTH, 4, AUX FIFO entries (power of 2, >= 2)
- STARVE_LIMIT, 3, consecutive lost cycles before the AUX head is forced through (>= 1)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  WB write request this cycle
- wb_dest  in  AW  WB destination register
- wb_data  in  WIDTH  WB write data
- wb_stall  out  1  WB write not performed this cycle; upstream holds and re-presents it
- aux_valid  in  1  AUX write offered
- aux_ready  out  1  FIFO can accept
- aux_dest  in  AW  AUX destination register
- aux_data  in  WIDTH  AUX write data
- issue_valid  in  1  long-latency op issued; its destination is marked pending
- issue_dest  in  AW  destination of the issued op
- load  out  NUM_REGS  one-hot (or zero) load enables to the register file
- wdata  out  WIDTH  shared write data to the register file
- pending  out  NUM_REGS  scoreboard: register awaits an AUX write

Behaviour:
- Reset is synchronous, active-high: reset high at a posedge clears all state. Outputs while reset is asserted:
  - load = 0
  - aux_ready = 0
  - wb_stall = 0
  - pending = 0
  - FIFO empty
  - starvation counter = 0
- State: AUX FIFO (DEPTH x {AW, WIDTH}), count (0..DEPTH), starvation counter wait_cnt, pending vector. All registered at posedge.
- Push: aux_ready = ~reset & (count != DEPTH), computed from registered count only. A push occurs on aux_valid & aux_ready.
- No bypass: an entry pushed in cycle N can be granted no earlier than cycle N+1.
- Grant is combinational on the current cycle's inputs and registered state:
  - force = (count != 0) & (wait_cnt == STARVE_LIMIT)
  - if force: AUX head granted; wb_stall = wb_valid
  - else if wb_valid: WB granted; wb_stall = 0
  - else if count != 0: AUX head granted
  - else: no grant, load = 0
- Outputs:
  - load = one-hot of the granted dest
  - wdata = granted data
  - both are driven in the same cycle and captured by the register file at that cycle's negedge, so the written value is readable in the second half of the cycle.
- Pop: the AUX head is popped at the posedge ending a cycle in which it was granted.
- Count update: push and pop in the same cycle leave count unchanged.
- Read/write pointers wrap modulo DEPTH.
- wait_cnt:
  - cleared on any AUX grant or when count == 0;
  - otherwise incremented when the head was present and not granted;
  - saturates at STARVE_LIMIT.
- Pending scoreboard:
  - issue_valid sets pending[issue_dest];
  - an AUX grant clears pending[granted dest];
  - if set and clear hit the same register in the same cycle, set wins;
  - WB writes never affect pending.
- Same dest in WB and AUX: they are serialized in grant order, and the later write determines the final value. This is architecturally correct, because decode never issues WB-writers to pending registers.
- Reset mid-operation: queued AUX entries are discarded and pending is cleared. The upstream units are reset by the same reset.
- Invariant: at most one bit of load is set in any cycle.

Test Plan:
- Reset, then WB only: wb_valid=1, wb_dest=3, wb_data=16'h1234 -> same cycle load=8'b0000_1000, wdata=16'h1234, wb_stall=0; with reset asserted the same stimulus gives load=0.
- Single AUX: issue_valid with dest=5 in cycle 0 gives pending[5]=1 from cycle 1. Push aux_dest=5, aux_data=16'hBEEF in cycle 1. Cycle 2: load[5]=1, wdata=16'hBEEF. Cycle 3: pending[5]=0 and count=0.
- Full FIFO: WB held valid every cycle and DEPTH=4 entries pushed -> aux_ready=0 once count=4; a push attempt is ignored and the FIFO contents are unchanged.
- Starvation (STARVE_LIMIT=3): one AUX entry queued with WB valid continuously -> WB is granted for 3 cycles; on the 4th cycle the AUX entry is granted, wb_stall=1 and the WB write is not performed; the next cycle WB is granted and wb_stall=0.
- Simultaneous push, pop and wrap: with count=1, push every cycle while popping every cycle (WB idle) for 10 cycles -> count stays 1, data emerges in FIFO order across pointer wrap, and no duplicate or lost entries.
- Set/clear collision: AUX grant to reg 2 in the same cycle as issue_valid, issue_dest=2 -> pending[2]=1 afterwards. Reset asserted with 3 queued entries -> next cycle count=0, pending=0, load=0.
